// File: rtl/puf_ctrl_if.sv
// rtl/puf_ctrl_if.sv - host/arbiter-facing signal bundle for the PUF measurement sequencer
interface puf_ctrl_if #(
  parameter int C_LENGTH = 3,
  parameter int C_CNT_W  = 3
);
  logic                    istart;
  logic [2*C_LENGTH-1:0]   ichallenge;
  logic                    iarb;
  logic                    opulse;
  logic [2*C_LENGTH-1:0]   ochallenge;
  logic                    obusy;
  logic                    odone;
  logic                    oresp;
  logic                    ostable;
  logic [C_CNT_W-1:0]      oones;

  modport master (
    output istart, ichallenge, iarb,
    input  opulse, ochallenge, obusy, odone, oresp, ostable, oones
  );

  modport slave (
    input  istart, ichallenge, iarb,
    output opulse, ochallenge, obusy, odone, oresp, ostable, oones
  );
endinterface

// File: rtl/puf_ctrl.sv
// rtl/puf_ctrl.sv - arbiter-PUF measurement sequencer with majority vote
module puf_ctrl #(
  parameter int C_LENGTH = 3,
  parameter int C_SETTLE = 4,
  parameter int C_WAIT   = 8,
  parameter int C_REPS   = 7,
  parameter int C_CNT_W  = $clog2(C_REPS + 1)
) (
  input logic        iclk,
  input logic        irst_n,
  puf_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_HOLD, S_SAMPLE, S_DONE
  } state_t;

  localparam int T_MAX = (C_SETTLE > C_WAIT) ? C_SETTLE : C_WAIT;
  localparam int T_W   = $clog2(T_MAX + 1);
  localparam logic [T_W-1:0]     T_SETTLE = T_W'(C_SETTLE - 1);
  localparam logic [T_W-1:0]     T_WAIT   = T_W'(C_WAIT - 1);
  localparam logic [C_CNT_W-1:0] REPS     = C_CNT_W'(C_REPS);
  localparam logic [C_CNT_W-1:0] HALF     = C_CNT_W'(C_REPS / 2);

  state_t                state, state_d;
  logic [T_W-1:0]        tmr, tmr_d;
  logic [C_CNT_W-1:0]    rep_cnt, rep_d, ones_cnt, ones_d;
  logic [C_CNT_W-1:0]    ones_inc, rep_inc;
  logic                  arb_s1, arb_s2;
  logic                  chal_load, res_load, pulse, done;
  logic [2*C_LENGTH-1:0] chal_q;
  logic                  resp_q, stable_q;
  logic [C_CNT_W-1:0]    ones_q;

  assign ones_inc = ones_cnt + C_CNT_W'(arb_s2);
  assign rep_inc  = rep_cnt + C_CNT_W'(1);

  always_comb begin
    state_d   = state;
    tmr_d     = tmr;
    rep_d     = rep_cnt;
    ones_d    = ones_cnt;
    chal_load = 1'b0;
    res_load  = 1'b0;
    pulse     = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.istart) begin
          chal_load = 1'b1;
          rep_d     = '0;
          ones_d    = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        tmr_d   = T_SETTLE;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (tmr == '0) begin
          tmr_d   = T_WAIT;
          state_d = S_HOLD;
        end else begin
          tmr_d = tmr - T_W'(1);
        end
      end
      S_HOLD: begin
        pulse = 1'b1;
        if (tmr == '0) state_d = S_SAMPLE;
        else           tmr_d   = tmr - T_W'(1);
      end
      S_SAMPLE: begin
        pulse  = 1'b1;
        ones_d = ones_inc;
        rep_d  = rep_inc;
        // Results are captured on the edge into DONE so they are valid alongside odone.
        if (rep_inc == REPS) begin
          res_load = 1'b1;
          state_d  = S_DONE;
        end else begin
          tmr_d   = T_SETTLE;
          state_d = S_SETTLE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      state    <= S_IDLE;
      tmr      <= '0;
      rep_cnt  <= '0;
      ones_cnt <= '0;
      arb_s1   <= 1'b0;
      arb_s2   <= 1'b0;
      chal_q   <= '0;
      resp_q   <= 1'b0;
      stable_q <= 1'b0;
      ones_q   <= '0;
    end else begin
      state    <= state_d;
      tmr      <= tmr_d;
      rep_cnt  <= rep_d;
      ones_cnt <= ones_d;
      arb_s1   <= bus.iarb;
      arb_s2   <= arb_s1;
      if (chal_load) chal_q <= bus.ichallenge;
      if (res_load) begin
        ones_q   <= ones_inc;
        resp_q   <= (ones_inc > HALF);
        stable_q <= (ones_inc == '0) || (ones_inc == REPS);
      end
    end
  end

  assign bus.opulse     = pulse;
  assign bus.ochallenge = chal_q;
  assign bus.obusy      = (state != S_IDLE);
  assign bus.odone      = done;
  assign bus.oresp      = resp_q;
  assign bus.ostable    = stable_q;
  assign bus.oones      = ones_q;

endmodule

// File: tb/tb_puf_ctrl.sv
// tb/tb_puf_ctrl.sv - directed table-driven bench for puf_ctrl
module tb_puf_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  puf_ctrl_if #(.C_LENGTH(3), .C_CNT_W(3)) bus ();
  puf_ctrl_if #(.C_LENGTH(3), .C_CNT_W(1)) bus2 ();

  puf_ctrl #(.C_LENGTH(3), .C_SETTLE(4), .C_WAIT(8), .C_REPS(7)) dut (
    .iclk   (clk),
    .irst_n (rst_n),
    .bus    (bus.slave)
  );

  puf_ctrl #(.C_LENGTH(3), .C_SETTLE(1), .C_WAIT(2), .C_REPS(1)) dut_min (
    .iclk   (clk),
    .irst_n (rst_n),
    .bus    (bus2.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [5:0] chal;
    logic       tied;
    logic [6:0] mask;
    int         exp_ones;
    logic       exp_resp;
    logic       exp_stable;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One measurement on the default instance; cycle c counts from the accepting edge.
  task automatic run(input vec_t v, input bit poke, input int ncyc);
    int   done_cnt  = 0;
    int   done_cyc  = 0;
    int   pulse_err = 0;
    logic busy_after = 1'b1;
    @(negedge clk);
    bus.istart     = 1'b1;
    bus.ichallenge = v.chal;
    bus.iarb       = v.tied;
    @(posedge clk);
    #1;
    bus.istart     = 1'b0;
    bus.ichallenge = ~v.chal;
    for (int c = 1; c <= ncyc; c++) begin
      int   f;
      int   off;
      logic exp_p;
      logic arb;
      @(negedge clk);
      f     = (c - 2) / 13;
      off   = (c - 2) % 13;
      exp_p = (c >= 2) && (f < 7) && (off >= 4);
      if (bus.opulse !== exp_p) pulse_err++;
      if (bus.odone === 1'b1) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c == 1) begin
        check("ochallenge_cycle1", 32'(bus.ochallenge), 32'(v.chal));
        check("obusy_cycle1", 32'(bus.obusy), 32'd1);
      end
      if (c == 93) begin
        check("oones", 32'(bus.oones), 32'(v.exp_ones));
        check("oresp", 32'(bus.oresp), 32'(v.exp_resp));
        check("ostable", 32'(bus.ostable), 32'(v.exp_stable));
      end
      if (c == 94) busy_after = bus.obusy;
      arb = v.tied;
      if (c >= 2 && f < 7 && off >= 4 && off <= 11) begin
        if (v.mask[f]) arb = 1'b1;
      end
      bus.iarb   = arb;
      bus.istart = poke && (c == 10 || c == 93);
      if (poke && (c == 10 || c == 93)) bus.ichallenge = 6'b010011;
    end
    bus.iarb   = 1'b0;
    bus.istart = 1'b0;
    check("odone_count", 32'(done_cnt), 32'd1);
    check("odone_cycle", 32'(done_cyc), 32'd93);
    check("opulse_shape_errors", 32'(pulse_err), 32'd0);
    check("ochallenge_held", 32'(bus.ochallenge), 32'(v.chal));
    if (ncyc >= 94) check("obusy_after_done", 32'(busy_after), 32'd0);
  endtask

  initial begin
    int   pulse_seen;
    int   done_seen;
    int   done_cyc;
    logic r_ones, r_resp, r_stab;

    vecs[0] = '{chal: 6'b101101, tied: 1'b1, mask: 7'b0000000, exp_ones: 7, exp_resp: 1'b1, exp_stable: 1'b1};
    vecs[1] = '{chal: 6'b110001, tied: 1'b0, mask: 7'b0101011, exp_ones: 4, exp_resp: 1'b1, exp_stable: 1'b0};
    vecs[2] = '{chal: 6'b011110, tied: 1'b0, mask: 7'b0010101, exp_ones: 3, exp_resp: 1'b0, exp_stable: 1'b0};
    vecs[3] = '{chal: 6'b010010, tied: 1'b0, mask: 7'b0000000, exp_ones: 0, exp_resp: 1'b0, exp_stable: 1'b1};
    vecs[4] = '{chal: 6'b111000, tied: 1'b0, mask: 7'b1000000, exp_ones: 1, exp_resp: 1'b0, exp_stable: 1'b0};
    vecs[5] = '{chal: 6'b000111, tied: 1'b0, mask: 7'b0111111, exp_ones: 6, exp_resp: 1'b1, exp_stable: 1'b0};

    rst_n           = 1'b0;
    bus.istart      = 1'b1;
    bus.ichallenge  = 6'h3f;
    bus.iarb        = 1'b1;
    bus2.istart     = 1'b1;
    bus2.ichallenge = 6'h2a;
    bus2.iarb       = 1'b0;

    // Reset held with istart asserted
    pulse_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.opulse !== 1'b0) pulse_seen++;
    end
    check("reset_opulse", 32'(pulse_seen), 32'd0);
    check("reset_obusy", 32'(bus.obusy), 32'd0);
    check("reset_odone", 32'(bus.odone), 32'd0);
    check("reset_oresp", 32'(bus.oresp), 32'd0);
    check("reset_ostable", 32'(bus.ostable), 32'd0);
    check("reset_oones", 32'(bus.oones), 32'd0);
    check("reset_ochallenge", 32'(bus.ochallenge), 32'd0);
    bus.istart  = 1'b0;
    bus.iarb    = 1'b0;
    bus2.istart = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Minimal configuration: one firing, shortest settle and wait
    @(negedge clk);
    bus2.istart = 1'b1;
    @(posedge clk);
    #1;
    bus2.istart = 1'b0;
    pulse_seen = 0;
    done_seen  = 0;
    done_cyc   = 0;
    r_ones = 1'b1; r_resp = 1'b1; r_stab = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus2.opulse !== ((c >= 3) && (c <= 5))) pulse_seen++;
      if (bus2.odone === 1'b1) begin
        done_seen++;
        done_cyc = c;
        r_ones = bus2.oones[0];
        r_resp = bus2.oresp;
        r_stab = bus2.ostable;
      end
    end
    check("min_odone_count", 32'(done_seen), 32'd1);
    check("min_odone_cycle", 32'(done_cyc), 32'd6);
    check("min_opulse_errors", 32'(pulse_seen), 32'd0);
    check("min_oones", 32'(r_ones), 32'd0);
    check("min_oresp", 32'(r_resp), 32'd0);
    check("min_ostable", 32'(r_stab), 32'd1);

    for (int i = 0; i < 6; i++) run(vecs[i], 1'b0, 100);

    // istart and challenge changes at cycle 10 and in DONE are ignored
    run(vecs[1], 1'b1, 100);

    // Back-to-back: restart in the first IDLE cycle after DONE
    run(vecs[2], 1'b0, 93);
    run(vecs[0], 1'b0, 100);

    // Reset in the middle of a measurement
    @(negedge clk);
    bus.istart     = 1'b1;
    bus.ichallenge = 6'b100110;
    bus.iarb       = 1'b1;
    @(posedge clk);
    #1;
    bus.istart = 1'b0;
    for (int c = 1; c < 40; c++) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_opulse", 32'(bus.opulse), 32'd0);
    check("midreset_obusy", 32'(bus.obusy), 32'd0);
    check("midreset_oones", 32'(bus.oones), 32'd0);
    check("midreset_oresp", 32'(bus.oresp), 32'd0);
    check("midreset_ostable", 32'(bus.ostable), 32'd0);
    rst_n    = 1'b1;
    bus.iarb = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.odone === 1'b1) done_seen++;
    end
    check("midreset_no_odone", 32'(done_seen), 32'd0);

    run(vecs[5], 1'b0, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
